// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, default timing and burst length.
package sdram_pkg;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP       = 4'b0111;
    localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
    localparam logic [3:0] CMD_READ      = 4'b0101;
    localparam logic [3:0] CMD_WRITE     = 4'b0100;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_AREF      = 4'b0001;
    localparam logic [3:0] CMD_MRS       = 4'b0000;

    localparam int CAS_LAT_DEF = 3;
    localparam int TRCD_DEF    = 2;
    localparam int TRP_DEF     = 2;
    localparam int BURST_LEN   = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACT,
        S_TRCD,
        S_READ,
        S_PRE,
        S_WAIT
    } rd_state_t;

endpackage

// File: rtl/sdram_rd_capture.sv
// Read-data capture: delays READ markers by the CAS latency, stretches each
// one into a burst-length valid window and registers the SDRAM data bus.
module sdram_rd_capture
    import sdram_pkg::*;
#(
    parameter int CAS_LAT = CAS_LAT_DEF,
    parameter int DATA_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              read_issue,
    input  logic [DATA_W-1:0] sdram_dq_in,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_vld
);

    // mark_p[k] is high k+1 cycles after a READ was on the bus
    logic [CAS_LAT:0] mark_p;
    logic [1:0]       tail;

    // READ-marker delay line; the last tap opens the valid window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mark_p <= '0;
        end else begin
            mark_p <= {mark_p[CAS_LAT-1:0], read_issue};
        end
    end

    // keep valid high for the remaining burst words after the marker tap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tail <= '0;
        end else if (mark_p[CAS_LAT]) begin
            tail <= 2'(BURST_LEN - 1);
        end else if (tail != 2'd0) begin
            tail <= tail - 2'd1;
        end
    end

    // register the data bus every cycle; rd_data_vld qualifies it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= sdram_dq_in;
        end
    end

    assign rd_data_vld = mark_p[CAS_LAT] | (tail != 2'd0);

endmodule

// File: rtl/sdram_read.sv
// SDRAM burst-read engine: requests the bus, opens a row, issues a run of
// 4-word READs, yields to refresh at burst boundaries and resumes later.
module sdram_read
    import sdram_pkg::*;
#(
    parameter int          BURST_TOTAL = 8,
    parameter logic [11:0] RD_ROW      = 12'd0,
    parameter logic [1:0]  RD_BANK     = 2'd0,
    parameter int          CAS_LAT     = CAS_LAT_DEF,
    parameter int          TRCD        = TRCD_DEF,
    parameter int          TRP         = TRP_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_trig,
    input  logic        ref_req,
    input  logic        rd_en,
    output logic        rd_req,
    output logic        flag_rd_end,
    output logic [3:0]  rd_cmd,
    output logic [11:0] rd_addr,
    output logic [1:0]  bank_addr,
    input  logic [15:0] sdram_dq_in,
    output logic [15:0] rd_data,
    output logic        rd_data_vld
);

    // the bus is held until both precharge and the data drain are complete
    localparam int WAIT_CYC = (TRP > CAS_LAT) ? TRP : CAS_LAT;

    rd_state_t  state, state_nxt;
    logic       pending;
    logic [6:0] burst_idx;
    logic [1:0] slot;
    logic [3:0] cnt;
    logic       last_burst;
    logic       read_issue;

    assign last_burst = (burst_idx == 7'(BURST_TOTAL));

    // state register with the per-state dwell counter and burst slot counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            slot  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (state_nxt != state) ? 4'd0 : cnt + 4'd1;
            slot  <= (state == S_READ) ? slot + 2'd1 : 2'd0;
        end
    end

    // job bookkeeping: pending flag and column position survive a refresh break
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= 1'b0;
            burst_idx <= '0;
        end else begin
            if (read_issue) begin
                burst_idx <= burst_idx + 7'd1;
            end else if (flag_rd_end && last_burst) begin
                burst_idx <= '0;
            end
            if (flag_rd_end && last_burst) begin
                pending <= 1'b0;
            end else if (rd_trig && !pending) begin
                pending <= 1'b1;
            end
        end
    end

    // next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (rd_en && pending) state_nxt = S_ACT;
            S_ACT:  state_nxt = (TRCD <= 1) ? S_READ : S_TRCD;
            S_TRCD: if (cnt == 4'(TRCD - 2)) state_nxt = S_READ;
            S_READ: if (slot == 2'd3 && (last_burst || ref_req)) state_nxt = S_PRE;
            S_PRE:  state_nxt = S_WAIT;
            S_WAIT: if (cnt == 4'(WAIT_CYC - 1)) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // command, address and handshake outputs decoded from the current state
    always_comb begin
        rd_cmd      = CMD_NOP;
        rd_addr     = 12'd0;
        bank_addr   = 2'd0;
        read_issue  = 1'b0;
        rd_req      = pending && (state == S_IDLE);
        flag_rd_end = (state == S_WAIT) && (cnt == 4'(WAIT_CYC - 1));
        case (state)
            S_ACT: begin
                rd_cmd    = CMD_ACTIVE;
                rd_addr   = RD_ROW;
                bank_addr = RD_BANK;
            end
            S_READ: begin
                if (slot == 2'd0) begin
                    rd_cmd     = CMD_READ;
                    rd_addr    = {4'b0000, burst_idx[5:0], 2'b00};
                    bank_addr  = RD_BANK;
                    read_issue = 1'b1;
                end
            end
            S_PRE: begin
                rd_cmd    = CMD_PRECHARGE;
                rd_addr   = 12'h400;
                bank_addr = RD_BANK;
            end
            default: ;
        endcase
    end

    sdram_rd_capture #(
        .CAS_LAT (CAS_LAT),
        .DATA_W  (16)
    ) u_capture (
        .clk         (clk),
        .rst_n       (rst_n),
        .read_issue  (read_issue),
        .sdram_dq_in (sdram_dq_in),
        .rd_data     (rd_data),
        .rd_data_vld (rd_data_vld)
    );

endmodule

// File: doc/sdram_read.md
# sdram_read

SDRAM burst-read engine: the read-side counterpart of the write engine under the same arbiter. A `rd_trig` pulse arms a read job of `BURST_TOTAL` bursts of 4 words each. The block then requests the bus from the arbiter with `rd_req` and, once granted via `rd_en`, drives ACTIVE / READ / PRECHARGE commands. It captures returning `sdram_dq` words into `rd_data` with a valid strobe, and yields to refresh at burst boundaries, resuming where it stopped.

## Interface
Parameters:
- `BURST_TOTAL`, 8: bursts per job; range 1..64, so the job stays within one row.
- `RD_ROW`, 12'd0: row address opened by ACTIVE.
- `RD_BANK`, 2'd0: bank for ACTIVE and READ.
- `CAS_LAT`, 3: CAS latency; must match the init mode register.
- `TRCD`, 2: cycles from ACTIVE to the first READ.
- `TRP`, 2: precharge time; must satisfy `TRP` ≤ `CAS_LAT`.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock (`sdram_clk` = ~`clk` at top).
- `rst_n`  in  1  asynchronous active-low reset.
- `rd_trig`  in  1  job start pulse.
- `ref_req`  in  1  refresh request from the refresh module.
- `rd_en`  in  1  one-cycle grant from the arbiter.
- `rd_req`  out  1  bus request (level).
- `flag_rd_end`  out  1  one-cycle pulse; bus released.
- `rd_cmd`  out  4  {cs_n,ras_n,cas_n,we_n}.
- `rd_addr`  out  12  SDRAM address.
- `bank_addr`  out  2  SDRAM bank.
- `sdram_dq_in`  in  16  SDRAM data bus, input view.
- `rd_data`  out  16  captured read word.
- `rd_data_vld`  out  1  `rd_data` valid.

## Operation
- Reset values: `rd_cmd`=NOP (4'b0111), `rd_addr`=0, `bank_addr`=0, `rd_req`=0, `flag_rd_end`=0, `rd_data`=0, `rd_data_vld`=0. The pending flag and all counters clear.
- Pending flag: set by `rd_trig` when clear; `rd_trig` while pending is ignored. Cleared in the `flag_rd_end` cycle of the final burst.
- `rd_req` = pending AND state==S_IDLE.
- States:
  - S_IDLE: `rd_en` → S_ACT.
  - S_ACT: one cycle, ACTIVE, `rd_addr`=`RD_ROW`, `bank_addr`=`RD_BANK` → S_TRCD.
  - S_TRCD: `TRCD`-1 cycles of NOP → S_READ.
  - S_READ: 4-cycle slot per burst.
    - Slot cycle 0: READ, `rd_addr`={4'b0000, burst_idx[5:0], 2'b00} (A10=0, no auto-precharge).
    - Slot cycles 1-3: NOP.
    - In slot cycle 3: if the burst count reached `BURST_TOTAL`, or `ref_req`=1 → S_PRE; else next slot.
  - S_PRE: one cycle, PRECHARGE, `rd_addr`=12'h400 (all banks) → S_WAIT.
  - S_WAIT: NOP for `CAS_LAT` cycles; `flag_rd_end`=1 in the last one → S_IDLE.
- burst_idx increments per issued READ. It is retained across a refresh interruption, so the resumed job continues at the next column; it clears on job completion.
- If refresh interrupts, pending stays 1 and `rd_req` reasserts the cycle after `flag_rd_end`.
- Capture:
  - Each READ produces 4 `rd_data_vld` cycles, starting `CAS_LAT`+1 cycles after the READ cycle.
  - `rd_data` is registered from `sdram_dq_in`.
- Reset mid-operation: immediate return to reset values. The job is abandoned and the capture pipeline is flushed.

## Timing
- A = first cycle after `rd_en` sampled high; ACTIVE is driven in cycle A.
- READ k (k=0..) at A+`TRCD`+4k.
- PRECHARGE at last READ+4.
- `flag_rd_end` at PRECHARGE+`CAS_LAT`, which coincides with the last `rd_data_vld`; the bus is never released before the final word.
- Defaults, 8 bursts:
  - READs at A+2 … A+30.
  - PRECHARGE at A+34.
  - `flag_rd_end` at A+37.
  - `rd_data_vld` high A+6..A+9, A+10..A+13, …, A+34..A+37: 32 consecutive cycles.
- `ref_req` is sampled only in slot cycle 3; a request arriving mid-burst waits for the burst to finish.
- `rd_en` outside S_IDLE is ignored.

## Structure
- Shared package `sdram_pkg`:
  - command constants NOP/ACTIVE/READ/WRITE/PRECHARGE/AREF/MRS;
  - `CAS_LAT`, `TRCD`, `TRP` defaults;
  - burst length 4.
- Sub-module `sdram_rd_capture`:
  - `CAS_LAT`+1-deep shift register of READ markers, expanded to 4-cycle valid;
  - `rd_data` register.

## Test plan
- Reset, `rd_trig` at cycle 10, `rd_en` pulse 3 cycles after `rd_req` rises → ACTIVE row 0, READs at cols 0,4,…,28, PRECHARGE addr 12'h400, 32 words in order, `flag_rd_end` at A+37, `rd_req` stays 0 afterwards.
- `ref_req`=1 during burst 2 (k=2) → PRECHARGE at A+14, 12 words, `flag_rd_end` at A+17, `rd_req` back at A+18. Regrant → ACTIVE, READs resume at col 12, 20 more words.
- `rd_trig` pulsed during an active job → ignored; exactly one job of 32 words.
- `BURST_TOTAL`=1 → one READ at col 0, PRECHARGE at A+6, 4 valid words, `flag_rd_end` at A+9.
- `rst_n` low at A+12 → all outputs at reset values at once, `rd_data_vld` never reasserts, `rd_req` stays 0 with no new trigger.
- Memory model preloaded with col*3 → `rd_data` matches per column, including across the refresh resume.
